// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control unit for a five-state multicycle MIPS-subset datapath.
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for branch/jump, ALU,
// load and store instructions. All strobes are combinational from the
// current state and the latched instruction fields. Memory accesses
// stretch on mem_ready.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; also forces every strobe low
//   opcode      IR[31:26] of the latched instruction
//   func        IR[5:0] of the latched instruction
//   zero        ALU equality flag, consulted in EXEC
//   mem_ready   memory handshake; access completes in the cycle it is high
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite   per-cycle datapath strobes
//   instr_done  one-cycle pulse in the retiring cycle
//   illegal     one-cycle pulse in EXEC for an unsupported encoding
//   state       current FSM state code
//   retire_cnt  retired-instruction count
//
// Build option:
//   MULTICYCLE_CTRL_RETIRE_CNT_EN  when defined, retire_cnt counts instr_done
//                                  pulses (wrapping); otherwise it is tied to 0
//                                  and no counter register is built.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | read instruction memory; load IR and PC+4 when mem_ready
// DECODE | register read, no strobes
// EXEC   | ALU op / branch resolve / jump; picks MEM, WB or FETCH
// MEM    | data memory read (lw) or write (sw), held until mem_ready
// WB     | register file write, instruction retires
// 5..7   | unreachable; recover to FETCH

module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  func,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        instr_done,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_q;
   state_t state_d;

   logic pc_write;
   logic ir_write;
   logic mem_read;
   logic mem_write;
   logic reg_write;
   logic done;
   logic illegal_op;
   logic rtype_ok;
   logic alu_class;

   always_comb begin
      rtype_ok = 1'b0;
      case (func)
         6'b100000, 6'b100010, 6'b100001, 6'b100011,
         6'b101010, 6'b000000, 6'b000010, 6'b000011: rtype_ok = 1'b1;
         default:                                    rtype_ok = 1'b0;
      endcase
   end

   always_comb begin
      alu_class = 1'b0;
      case (opcode)
         OP_ORI, OP_LUI, OP_SLTI: alu_class = 1'b1;
         OP_RTYPE:                alu_class = rtype_ok;
         default:                 alu_class = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      done       = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else begin
               state_d  = S_FETCH;
            end
         end

         S_DECODE: begin
            state_d = S_EXEC;
         end

         S_EXEC: begin
            case (opcode)
               OP_BEQ: begin
                  pc_write = zero;
                  done     = 1'b1;
               end
               OP_BNE: begin
                  pc_write = ~zero;
                  done     = 1'b1;
               end
               OP_J: begin
                  pc_write = 1'b1;
                  done     = 1'b1;
               end
               OP_LW, OP_SW: begin
                  state_d = S_MEM;
               end
               default: begin
                  if (alu_class) begin
                     state_d = S_WB;
                  end else begin
                     illegal_op = 1'b1;
                  end
               end
            endcase
         end

         S_MEM: begin
            if (opcode == OP_LW) begin
               mem_read = 1'b1;
               state_d  = mem_ready ? S_WB : S_MEM;
            end else if (opcode == OP_SW) begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  done = 1'b1;
               end else begin
                  state_d = S_MEM;
               end
            end
         end

         S_WB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Reset must also gate the strobes of the current cycle so an access
      // in flight never produces a partial write.
      if (rst) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         done       = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign PCWrite    = pc_write;
   assign IRWrite    = ir_write;
   assign MemRead    = mem_read;
   assign MemWrite   = mem_write;
   assign RegWrite   = reg_write;
   assign instr_done = done;
   assign illegal    = illegal_op;
   assign state      = state_q;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt_q <= 32'd0;
      end else if (done) begin
         retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign retire_cnt = retire_cnt_q;
`else
   assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// Expected per-cycle behaviour is built instruction by instruction from the
// class of each instruction (branch/jump, ALU, load, store, illegal) and its
// memory wait counts; a single negedge process compares DUT outputs to it.

module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        zero;
   logic        mem_ready;
   logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
   logic        instr_done;
   logic        illegal;
   logic [2:0]  state;
   logic [31:0] retire_cnt;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   multicycle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .func       (func),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .instr_done (instr_done),
      .illegal    (illegal),
      .state      (state),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        chk_en = 1'b0;
   logic [2:0]  exp_state;
   logic        exp_pcw, exp_irw, exp_mr, exp_mw, exp_rw, exp_dn, exp_il;
   logic [31:0] exp_cnt = 32'd0;

   int cyc_cnt = 0;
   int done_at = -1;

   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101;
   localparam logic [5:0] JMP = 6'b000010;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cyc_cnt++;
         chk("state",      32'(state),      32'(exp_state));
         chk("PCWrite",    32'(PCWrite),    32'(exp_pcw));
         chk("IRWrite",    32'(IRWrite),    32'(exp_irw));
         chk("MemRead",    32'(MemRead),    32'(exp_mr));
         chk("MemWrite",   32'(MemWrite),   32'(exp_mw));
         chk("RegWrite",   32'(RegWrite),   32'(exp_rw));
         chk("instr_done", 32'(instr_done), 32'(exp_dn));
         chk("illegal",    32'(illegal),    32'(exp_il));
         chk("retire_cnt", retire_cnt,      exp_cnt);
         if (instr_done === 1'b1) done_at = cyc_cnt;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // 0 branch/jump, 1 ALU, 2 lw, 3 sw, 4 illegal
   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         BEQ, BNE, JMP:                   return 0;
         LW:                              return 2;
         SW:                              return 3;
         6'b001101, 6'b001111, 6'b001010: return 1;
         6'b000000: begin
            case (fn)
               6'b100000, 6'b100010, 6'b100001, 6'b100011,
               6'b101010, 6'b000000, 6'b000010, 6'b000011: return 1;
               default:                                    return 4;
            endcase
         end
         default:                         return 4;
      endcase
   endfunction

   function automatic logic [5:0] rnd6();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive inputs, publish expected outputs, advance.
   task automatic step(input logic [2:0] st,
                       input logic pcw, input logic irw, input logic mr,
                       input logic mw, input logic rw, input logic dn,
                       input logic il, input logic mrdy,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic r);
      rst       = r;
      opcode    = op;
      func      = fn;
      zero      = z;
      mem_ready = mrdy;
      exp_state = st;
      exp_pcw   = pcw;
      exp_irw   = irw;
      exp_mr    = mr;
      exp_mw    = mw;
      exp_rw    = rw;
      exp_dn    = dn;
      exp_il    = il;
      chk_en    = 1'b1;
      @(posedge clk);
      #1;
      if (r) exp_cnt = 32'd0;
      else if (dn && CNT_EN) exp_cnt = exp_cnt + 32'd1;
   endtask

   // Runs one instruction from FETCH to retirement; lat is the number of
   // cycles from the first FETCH cycle to the DUT's instr_done pulse.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int wf, input int wm,
                            output int lat);
      int k;
      int start;
      logic pcw;
      k       = classify(op, fn);
      start   = cyc_cnt;
      done_at = -1;
      for (int i = 0; i < wf; i++)
         step(3'd0, 0, 0, 1, 0, 0, 0, 0, 1'b0, rnd6(), rnd6(), rnd1(), 1'b0);
      step(3'd0, 1, 1, 1, 0, 0, 0, 0, 1'b1, rnd6(), rnd6(), rnd1(), 1'b0);
      step(3'd1, 0, 0, 0, 0, 0, 0, 0, rnd1(), rnd6(), rnd6(), rnd1(), 1'b0);
      pcw = (op == BEQ) ? z : (op == BNE) ? ~z : (op == JMP);
      step(3'd2, pcw, 0, 0, 0, 0, (k == 0), (k == 4), rnd1(), op, fn, z, 1'b0);
      if (k == 1) begin
         step(3'd4, 0, 0, 0, 0, 1, 1, 0, rnd1(), op, fn, rnd1(), 1'b0);
      end else if (k == 2) begin
         for (int i = 0; i < wm; i++)
            step(3'd3, 0, 0, 1, 0, 0, 0, 0, 1'b0, op, fn, rnd1(), 1'b0);
         step(3'd3, 0, 0, 1, 0, 0, 0, 0, 1'b1, op, fn, rnd1(), 1'b0);
         step(3'd4, 0, 0, 0, 0, 1, 1, 0, rnd1(), op, fn, rnd1(), 1'b0);
      end else if (k == 3) begin
         for (int i = 0; i < wm; i++)
            step(3'd3, 0, 0, 0, 1, 0, 0, 0, 1'b0, op, fn, rnd1(), 1'b0);
         step(3'd3, 0, 0, 0, 1, 0, 1, 0, 1'b1, op, fn, rnd1(), 1'b0);
      end
      lat = (done_at < 0) ? -1 : (done_at - start);
   endtask

   function automatic int base_latency(input int k);
      case (k)
         0:       return 3;
         1:       return 4;
         2:       return 5;
         3:       return 4;
         default: return -1;
      endcase
   endfunction

   logic [5:0] legal_fn [8] = '{6'b100000, 6'b100010, 6'b100001, 6'b100011,
                                6'b101010, 6'b000000, 6'b000010, 6'b000011};
   logic [5:0] legal_op [9] = '{BEQ, BNE, JMP, LW, SW, 6'b001101, 6'b001111,
                                6'b001010, 6'b000000};

   initial begin
      int lat;
      rst       = 1'b1;
      opcode    = 6'd0;
      func      = 6'd0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset held: state FETCH, every strobe gated, counter cleared
      step(3'd0, 0, 0, 0, 0, 0, 0, 0, 1'b1, LW, 6'd0, 1'b0, 1'b1);

      // addu: 0,1,2,4 then retire
      run_instr(6'b000000, 6'b100001, 1'b0, 0, 0, lat);
      chk("addu_latency", 32'(lat), 32'd4);

      // lw with two memory wait cycles
      run_instr(LW, rnd6(), 1'b0, 0, 2, lat);
      chk("lw_wait_latency", 32'(lat), 32'd7);

      // beq taken then not taken
      run_instr(BEQ, rnd6(), 1'b1, 0, 0, lat);
      chk("beq_taken_latency", 32'(lat), 32'd3);
      run_instr(BEQ, rnd6(), 1'b0, 0, 0, lat);
      chk("beq_nt_latency", 32'(lat), 32'd3);

      // illegal opcode: no retirement
      run_instr(6'b111111, rnd6(), 1'b0, 0, 0, lat);
      chk("illegal_no_done", 32'(lat), 32'hFFFF_FFFF);

      // sw with a fetch stall, then reset during MEM
      step(3'd0, 0, 0, 1, 0, 0, 0, 0, 1'b0, rnd6(), rnd6(), 1'b0, 1'b0);
      step(3'd0, 1, 1, 1, 0, 0, 0, 0, 1'b1, rnd6(), rnd6(), 1'b0, 1'b0);
      step(3'd1, 0, 0, 0, 0, 0, 0, 0, 1'b0, rnd6(), rnd6(), 1'b0, 1'b0);
      step(3'd2, 0, 0, 0, 0, 0, 0, 0, 1'b0, SW, 6'd0, 1'b0, 1'b0);
      step(3'd3, 0, 0, 0, 1, 0, 0, 0, 1'b0, SW, 6'd0, 1'b0, 1'b0);
      step(3'd3, 0, 0, 0, 0, 0, 0, 0, 1'b1, SW, 6'd0, 1'b0, 1'b1);
      chk("cnt_after_rst", retire_cnt, 32'd0);

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
      dut.retire_cnt_q = 32'hFFFF_FFFF;
      exp_cnt          = 32'hFFFF_FFFF;
`endif
      run_instr(JMP, rnd6(), rnd1(), 1, 0, lat);
      chk("j_latency", 32'(lat), 32'd4);
      chk("cnt_after_j", retire_cnt, 32'd0);

      // sw with waits
      run_instr(SW, rnd6(), 1'b0, 0, 1, lat);
      chk("sw_wait_latency", 32'(lat), 32'd5);

      // randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         int k;
         int wf;
         int wm;
         if ($urandom_range(0, 3) == 0) op = rnd6();
         else op = legal_op[$urandom_range(0, 8)];
         if (op == 6'd0 && $urandom_range(0, 3) != 0) fn = legal_fn[$urandom_range(0, 7)];
         else fn = rnd6();
         wf = $urandom_range(0, 2);
         wm = $urandom_range(0, 2);
         k  = classify(op, fn);
         run_instr(op, fn, rnd1(), wf, wm, lat);
         if (k == 4)
            chk("rand_illegal_no_done", 32'(lat), 32'hFFFF_FFFF);
         else if (k >= 2)
            chk("rand_mem_latency", 32'(lat), 32'(base_latency(k) + wf + wm));
         else
            chk("rand_latency", 32'(lat), 32'(base_latency(k) + wf));
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
